// File: rtl/otp_ctrl_dai_arbiter.sv
// Round-robin arbiter that shares the OTP Direct Access Interface between the
// Caliptra core (requester 0) and the MCU core (requester 1), with window checks.
module otp_ctrl_dai_arbiter #(
    parameter int unsigned          AddrWidth     = 12,
    parameter logic [AddrWidth-1:0] Lower0        = AddrWidth'('h000),
    parameter logic [AddrWidth-1:0] Upper0        = AddrWidth'('hFFF),
    parameter logic [AddrWidth-1:0] Lower1        = AddrWidth'('h088),
    parameter logic [AddrWidth-1:0] Upper1        = AddrWidth'('hFFF),
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [5:0]             req_cmd_i,
    input  logic [2*AddrWidth-1:0] req_addr_i,
    input  logic [127:0]           req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [2:0]             rsp_err_o,
    output logic [63:0]            rsp_rdata_o,
    output logic                   dai_req_o,
    output logic [2:0]             dai_cmd_o,
    output logic [AddrWidth-1:0]   dai_addr_o,
    output logic [63:0]            dai_wdata_o,
    input  logic                   dai_idle_i,
    input  logic                   dai_done_i,
    input  logic [2:0]             dai_err_i,
    input  logic [63:0]            dai_rdata_i,
    output logic                   fatal_err_o
);

    typedef enum logic [2:0] {
        NoError              = 3'h0,
        MacroError           = 3'h1,
        MacroEccCorrError    = 3'h2,
        MacroEccUncorrError  = 3'h3,
        MacroWriteBlankError = 3'h4,
        AccessError          = 3'h5,
        CheckFailError       = 3'h6,
        FsmStateError        = 3'h7
    } otp_err_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StError
    } state_e;

    localparam int unsigned          CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0]      CntMax = CntW'(TimeoutCycles - 1);

    state_e                 state_q, state_d;
    logic                   last_grant_q;
    logic                   id_q;
    logic                   pend_q;
    logic [2:0]             cmd_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [63:0]            wdata_q;
    logic [2:0]             err_q;
    logic [63:0]            rdata_q;
    logic [CntW-1:0]        cnt_q;

    logic                   win;
    logic                   grant_en;
    logic                   grant;
    logic [2:0]             win_cmd;
    logic [AddrWidth-1:0]   win_addr;
    logic [63:0]            win_wdata;
    logic [AddrWidth-1:0]   win_lo;
    logic [AddrWidth-1:0]   win_hi;
    logic [AddrWidth:0]     addr_off;
    logic [AddrWidth:0]     win_span;
    logic                   cmd_ok;
    logic                   legal;

    assign win       = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
    assign grant_en  = (state_q == StIdle) || ((state_q == StError) && !pend_q);
    assign grant     = grant_en && (|req_valid_i);
    assign win_cmd   = win ? req_cmd_i[5:3] : req_cmd_i[2:0];
    assign win_addr  = win ? req_addr_i[2*AddrWidth-1:AddrWidth] : req_addr_i[AddrWidth-1:0];
    assign win_wdata = win ? req_wdata_i[127:64] : req_wdata_i[63:0];
    assign win_lo    = win ? Lower1 : Lower0;
    assign win_hi    = win ? Upper1 : Upper0;

    // Window test as one widened offset compare: an address below Lower wraps
    // to a value above the span, so no comparison degenerates when Lower is 0.
    assign addr_off  = {1'b0, win_addr} - {1'b0, win_lo};
    assign win_span  = {1'b0, win_hi} - {1'b0, win_lo};
    assign cmd_ok    = (win_cmd == 3'b001) || (win_cmd == 3'b010) || (win_cmd == 3'b100);
    assign legal     = cmd_ok && !win_addr[0] && (addr_off <= win_span);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant) state_d = legal ? StIssue : StResp;
            end
            StIssue: begin
                if (dai_idle_i) state_d = StWait;
            end
            StWait: begin
                if (dai_done_i)           state_d = StResp;
                else if (cnt_q == CntMax) state_d = StError;
            end
            StResp:  state_d = StIdle;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = '0;
        rsp_rdata_o = '0;
        dai_req_o   = 1'b0;
        dai_cmd_o   = '0;
        dai_addr_o  = '0;
        dai_wdata_o = '0;
        fatal_err_o = (state_q == StError);
        if (grant) req_ready_o[win] = 1'b1;
        if ((state_q == StResp) || ((state_q == StError) && pend_q)) begin
            rsp_valid_o[id_q] = 1'b1;
            rsp_err_o         = err_q;
            rsp_rdata_o       = rdata_q;
        end
        if (state_q == StIssue) begin
            dai_req_o   = dai_idle_i;
            dai_cmd_o   = cmd_q;
            dai_addr_o  = addr_q;
            dai_wdata_o = wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            pend_q       <= 1'b0;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            pend_q <= grant && (state_q == StError);
            if (grant) begin
                last_grant_q <= win;
                id_q         <= win;
                cmd_q        <= win_cmd;
                addr_q       <= win_addr;
                wdata_q      <= win_wdata;
                if (state_q == StError) begin
                    err_q   <= FsmStateError;
                    rdata_q <= '0;
                end else if (!legal) begin
                    err_q   <= AccessError;
                    rdata_q <= '0;
                end
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
                if (dai_done_i) begin
                    err_q   <= dai_err_i;
                    rdata_q <= dai_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_otp_ctrl_dai_arbiter.sv
// Directed plus randomized bench for otp_ctrl_dai_arbiter; expectations come from
// a transaction-level model of grant order, legality and response timing.
module tb_otp_ctrl_dai_arbiter;

    localparam int unsigned AW  = 12;
    localparam int unsigned TO  = 1024;
    localparam logic [11:0] L0  = 12'h000;
    localparam logic [11:0] U0  = 12'hFFF;
    localparam logic [11:0] L1  = 12'h088;
    localparam logic [11:0] U1  = 12'hFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2:0]    c0, c1;
    logic [11:0]   a0, a1;
    logic [63:0]   w0, w1;
    logic [1:0]    rsp_valid;
    logic [2:0]    rsp_err;
    logic [63:0]   rsp_rdata;
    logic          dai_req;
    logic [2:0]    dai_cmd;
    logic [11:0]   dai_addr;
    logic [63:0]   dai_wdata;
    logic          dai_idle;
    logic          dai_done;
    logic [2:0]    dai_err;
    logic [63:0]   dai_rdata;
    logic          fatal;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic          model_last;

    always #5 clk = ~clk;

    otp_ctrl_dai_arbiter #(
        .AddrWidth    (AW),
        .Lower0       (L0),
        .Upper0       (U0),
        .Lower1       (L1),
        .Upper1       (U1),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_cmd_i   ({c1, c0}),
        .req_addr_i  ({a1, a0}),
        .req_wdata_i ({w1, w0}),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_rdata_o (rsp_rdata),
        .dai_req_o   (dai_req),
        .dai_cmd_o   (dai_cmd),
        .dai_addr_o  (dai_addr),
        .dai_wdata_o (dai_wdata),
        .dai_idle_i  (dai_idle),
        .dai_done_i  (dai_done),
        .dai_err_i   (dai_err),
        .dai_rdata_i (dai_rdata),
        .fatal_err_o (fatal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic who);
        return who ? 2'b10 : 2'b01;
    endfunction

    function automatic logic legal_m(input logic who, input logic [2:0] c, input logic [11:0] a);
        int unsigned lo, hi, av;
        lo = who ? int'(L1) : int'(L0);
        hi = who ? int'(U1) : int'(U0);
        av = int'(a);
        return (c == 3'b001 || c == 3'b010 || c == 3'b100) && (a[0] == 1'b0) && av >= lo && av <= hi;
    endfunction

    // One arbitrated request; done_dly == 0 means the DAI never completes.
    task automatic run_txn(input logic [1:0] mask, input logic hold, input int idle_dly,
                           input int done_dly, input logic [2:0] derr, input logic [63:0] drd,
                           input string tag);
        logic        w, lg, ok;
        logic [2:0]  ec;
        logic [11:0] ea;
        logic [63:0] ew;
        w  = (mask == 2'b11) ? ~model_last : mask[1];
        model_last = w;
        ec = w ? c1 : c0;
        ea = w ? a1 : a0;
        ew = w ? w1 : w0;
        lg = legal_m(w, ec, ea);
        @(negedge clk);
        req_valid = mask;
        #1;
        chk({tag, ".ready"}, req_ready, onehot(w));
        chk({tag, ".rsp_quiet"}, rsp_valid, 0);
        @(negedge clk);
        if (!hold) req_valid = '0;
        if (!lg) begin
            #1;
            chk({tag, ".deny_valid"}, rsp_valid, onehot(w));
            chk({tag, ".deny_err"}, rsp_err, 3'h5);
            chk({tag, ".deny_rdata"}, rsp_rdata, 0);
            chk({tag, ".deny_nodai"}, dai_req, 0);
            chk({tag, ".deny_noready"}, req_ready, 0);
            return;
        end
        for (int k = 0; k < idle_dly; k++) begin
            dai_idle = 1'b0;
            #1;
            chk({tag, ".busy_noreq"}, dai_req, 0);
            @(negedge clk);
        end
        dai_idle = 1'b1;
        #1;
        chk({tag, ".issue"}, dai_req, 1);
        chk({tag, ".issue_cmd"}, dai_cmd, ec);
        chk({tag, ".issue_addr"}, dai_addr, ea);
        chk({tag, ".issue_wdata"}, dai_wdata, ew);
        chk({tag, ".issue_noready"}, req_ready, 0);
        if (done_dly == 0) begin
            ok = 1'b1;
            for (int k = 0; k < int'(TO); k++) begin
                @(negedge clk);
                #1;
                ok = ok && (dai_req == 1'b0) && (rsp_valid == 2'b00) && (fatal == 1'b0);
            end
            chk({tag, ".wait_quiet"}, ok, 1);
            @(negedge clk);
            #1;
            chk({tag, ".fatal"}, fatal, 1);
            chk({tag, ".no_rsp"}, rsp_valid, 0);
            return;
        end
        for (int k = 0; k < done_dly; k++) begin
            @(negedge clk);
            if (k == done_dly - 1) begin
                dai_done  = 1'b1;
                dai_err   = derr;
                dai_rdata = drd;
            end
            #1;
            chk({tag, ".wait_noreq"}, {rsp_valid, dai_req}, 0);
        end
        @(negedge clk);
        dai_done  = 1'b0;
        dai_err   = '0;
        dai_rdata = '0;
        #1;
        chk({tag, ".rsp_valid"}, rsp_valid, onehot(w));
        chk({tag, ".rsp_err"}, rsp_err, derr);
        chk({tag, ".rsp_rdata"}, rsp_rdata, drd);
        chk({tag, ".rsp_noready"}, req_ready, 0);
    endtask

    task automatic err_txn(input logic [1:0] mask, input string tag);
        logic w;
        w = (mask == 2'b11) ? ~model_last : mask[1];
        model_last = w;
        @(negedge clk);
        req_valid = mask;
        #1;
        chk({tag, ".ready"}, req_ready, onehot(w));
        chk({tag, ".fatal"}, fatal, 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, ".rsp_valid"}, rsp_valid, onehot(w));
        chk({tag, ".rsp_err"}, rsp_err, 3'h7);
        chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
        chk({tag, ".noready"}, req_ready, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, req_ready, 0);
        chk({tag, ".rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk({tag, ".dai"}, {dai_req, dai_cmd, dai_addr, dai_wdata[31:0]}, 0);
        chk({tag, ".dai_wdata"}, dai_wdata, 0);
        chk({tag, ".fatal"}, fatal, 0);
    endtask

    initial begin
        logic [1:0] m;
        int unsigned r;
        rst_n = 1'b0;
        req_valid = '0;
        c0 = '0; c1 = '0; a0 = '0; a1 = '0; w0 = '0; w1 = '0;
        dai_idle = 1'b1; dai_done = 1'b0; dai_err = '0; dai_rdata = '0;
        model_last = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        c0 = 3'b001; a0 = 12'h010; w0 = {$urandom, $urandom};
        run_txn(2'b01, 1'b0, 0, 1, 3'h0, 64'hA5A5_0000_1234_5678, "t1_read");

        c1 = 3'b010; a1 = 12'h040; w1 = {$urandom, $urandom};
        run_txn(2'b10, 1'b0, 0, 1, 3'h0, 64'h0, "t2_below_window");

        c0 = 3'b001; a0 = 12'h100; c1 = 3'b001; a1 = 12'h200;
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 1'b1, 0, 1, 3'h0, {$urandom, $urandom}, "t3_rr");
        req_valid = '0;

        c0 = 3'b011; a0 = 12'h010;
        run_txn(2'b01, 1'b0, 0, 1, 3'h0, 64'h0, "t4_badcmd");
        c0 = 3'b001; a0 = 12'h011;
        run_txn(2'b01, 1'b0, 0, 1, 3'h0, 64'h0, "t4_unaligned");
        c1 = 3'b001; a1 = 12'h088;
        run_txn(2'b10, 1'b0, 0, 2, 3'h0, 64'h1111_2222_3333_4444, "t4_lower1_edge");
        c1 = 3'b100; a1 = 12'h086;
        run_txn(2'b10, 1'b0, 0, 1, 3'h0, 64'h0, "t4_below_lower1");

        c0 = 3'b010; a0 = 12'h020; w0 = 64'hDEAD_BEEF_0BAD_F00D;
        run_txn(2'b01, 1'b0, 5, 1, 3'h2, {$urandom, $urandom}, "t5_busy");

        @(negedge clk);
        dai_done = 1'b1; dai_err = 3'h3; dai_rdata = 64'hFFFF;
        #1;
        chk("stray_done", {rsp_valid, dai_req}, 0);
        @(negedge clk);
        dai_done = 1'b0; dai_err = '0; dai_rdata = '0;
        #1;
        chk("stray_done_after", rsp_valid, 0);

        for (int unsigned i = 0; i < 40; i++) begin
            m = 2'($urandom_range(1, 3));
            r = $urandom_range(0, 7);
            c0 = (r < 6) ? 3'(1 << (r % 3)) : 3'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            c1 = (r < 6) ? 3'(1 << (r % 3)) : 3'($urandom_range(0, 7));
            a0 = 12'($urandom_range(0, 4095));
            a1 = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 255)) : 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 4) != 0) a0[0] = 1'b0;
            if ($urandom_range(0, 4) != 0) a1[0] = 1'b0;
            w0 = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            run_txn(m, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                    3'($urandom_range(0, 7)), {$urandom, $urandom}, "rand");
        end

        c0 = 3'b001; a0 = 12'h030;
        run_txn(2'b01, 1'b0, 0, 0, 3'h0, 64'h0, "t6_timeout");
        c0 = 3'b001; a0 = 12'h010; c1 = 3'b001; a1 = 12'h100;
        err_txn(2'b01, "t6_err0");
        err_txn(2'b11, "t6_err_both_a");
        err_txn(2'b11, "t6_err_both_b");
        err_txn(2'b10, "t6_err1");

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        run_txn(2'b11, 1'b0, 0, 1, 3'h0, 64'h0123_4567_89AB_CDEF, "t6_resume");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
